counter_sequencer: RTL and testbench

Control block for the 8-bit T-flip-flop counter on the lab board: issues single-cycle count enables at a selectable rate, clears the counter on start, stops at a programmable terminal value, and supports stop/resume and single-step. Sits between the switch/key input layer and the counter's enable/clear pins, observing the counter's value to decide when to stop.

---
 rtl/counter_sequencer_if.sv | 27 ++
 rtl/counter_sequencer.sv | 146 ++++++++++++++
 tb/tb_counter_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Command, status and counter-feedback bundle between the switch/key layer, the sequencer and the counter.
interface counter_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             step;
    logic [1:0]       rate_sel;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic             cnt_en;
    logic             cnt_clr_b;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [2:0]       state;

    modport master (
        output start, stop, step, rate_sel, limit, count,
        input  cnt_en, cnt_clr_b, busy, done, wrap, state
    );

    modport slave (
        input  start, stop, step, rate_sel, limit, count,
        output cnt_en, cnt_clr_b, busy, done, wrap, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencer for the lab T-FF counter: rate-divided count enables, clear on start, stop at limit, hold/step.
// Latency: cnt_en/cnt_clr_b are registered, one cycle after the deciding command or divider tick.
// No backpressure; a step landing right after a pulse is deferred one cycle. SEQ_AUTORELOAD_EN: cycle 0..limit.
module counter_sequencer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic              clock,
    input  logic              clear_b,
    counter_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_b_q;
    logic             step_pend_q, step_pend_d;
    logic             at_limit;
    logic             settled;
    logic             step_req;
    logic [DIV_W-1:0] reload_val;
`ifdef SEQ_AUTORELOAD_EN
    logic             wrap_q, wrap_d;
`endif

    function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] sel);
        case (sel)
            2'd0:    period_m1 = DIV_W'(TICK_DIV - 1);
            2'd1:    period_m1 = DIV_W'(TICK_DIV / 2 - 1);
            2'd2:    period_m1 = DIV_W'(TICK_DIV / 4 - 1);
            default: period_m1 = DIV_W'(1);
        endcase
    endfunction

    // The counter value is only trusted when no enable went out in the previous cycle.
    assign at_limit   = (bus.count == bus.limit);
    assign settled    = !cnt_en_q;
    assign step_req   = bus.step | step_pend_q;
    assign reload_val = period_m1(bus.rate_sel);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_en_d    = 1'b0;
        step_pend_d = 1'b0;
`ifdef SEQ_AUTORELOAD_EN
        wrap_d      = 1'b0;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    if (state_q == IDLE) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = RUN;
                        div_d   = reload_val;
                    end
                end else if (step_req) begin
                    // A pending step plus a fresh one: issue one now, keep the other queued.
                    if (!settled) begin
                        step_pend_d = 1'b1;
                    end else begin
                        cnt_en_d    = !at_limit;
                        step_pend_d = step_pend_q & bus.step;
                    end
                end
            end
            CLEAR: begin
                state_d = RUN;
                div_d   = reload_val;
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = HOLD;
                end else if (settled && at_limit) begin
`ifdef SEQ_AUTORELOAD_EN
                    state_d = CLEAR;
                    wrap_d  = 1'b1;
`else
                    state_d = DONE;
`endif
                end else if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else if (settled) begin
                    div_d    = reload_val;
                    cnt_en_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_b_q <= 1'b1;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_b_q <= (state_d != CLEAR);
            step_pend_q <= step_pend_d;
        end
    end

`ifdef SEQ_AUTORELOAD_EN
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
    assign bus.wrap = wrap_q;
`else
    assign bus.wrap = 1'b0;
`endif

    assign bus.cnt_en    = cnt_en_q;
    assign bus.cnt_clr_b = cnt_clr_b_q;
    assign bus.busy      = (state_q == CLEAR) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 8-bit counter closing the count loop.
module tb_counter_sequencer;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 8;
    localparam int DIV_W    = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic clock   = 1'b0;
    logic clear_b = 1'b0;
    always #5 clock = ~clock;

    counter_sequencer_if #(.CNT_W(CNT_W)) bif ();

    counter_sequencer #(
        .CNT_W   (CNT_W),
        .TICK_DIV(TICK_DIV),
        .DIV_W   (DIV_W)
    ) dut (
        .clock  (clock),
        .clear_b(clear_b),
        .bus    (bif.slave)
    );

    logic [CNT_W-1:0] cnt_q = '0;
    always @(posedge clock) begin
        if (!bif.cnt_clr_b) cnt_q <= '0;
        else if (bif.cnt_en) cnt_q <= cnt_q + 1'b1;
    end
    assign bif.count = cnt_q;

    int cyc = 0, npulse = 0, nclr = 0, nwrap = 0, ndone = 0, last_pulse = 0, gap = 0;
    always @(posedge clock) begin
        cyc++;
        if (bif.cnt_en) begin
            gap = cyc - last_pulse;
            last_pulse = cyc;
            npulse++;
        end
        if (!bif.cnt_clr_b) nclr++;
        if (bif.wrap) nwrap++;
        if (bif.done) ndone++;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start;
        bif.start = 1'b1;
        @(negedge clock);
        bif.start = 1'b0;
    endtask

    task automatic pulse_stop;
        bif.stop = 1'b1;
        @(negedge clock);
        bif.stop = 1'b0;
    endtask

    task automatic pulse_step;
        bif.step = 1'b1;
        @(negedge clock);
        bif.step = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int i = 0;
        while (bif.state !== s && i < budget) begin
            @(negedge clock);
            i++;
        end
        check_val(tag, 32'(bif.state), 32'(s));
    endtask

    task automatic wait_count(input string tag, input logic [CNT_W-1:0] v, input int budget);
        int i = 0;
        while (bif.count !== v && i < budget) begin
            @(negedge clock);
            i++;
        end
        check_val(tag, 32'(bif.count), 32'(v));
    endtask

    initial begin
        int np0;
        int nclr0;
        int first;
        bif.start    = 1'b0;
        bif.stop     = 1'b0;
        bif.step     = 1'b0;
        bif.rate_sel = 2'd0;
        bif.limit    = '0;

        cyc_n(2);
        check_val("rst_state", 32'(bif.state), 32'(S_IDLE));
        check_val("rst_cnt_en", 32'(bif.cnt_en), 0);
        check_val("rst_clr_b", 32'(bif.cnt_clr_b), 1);
        check_val("rst_busy", 32'(bif.busy), 0);
        check_val("rst_done", 32'(bif.done), 0);
        check_val("rst_wrap", 32'(bif.wrap), 0);
        clear_b = 1'b1;
        cyc_n(1);

        // Reset in the middle of a run.
        bif.limit    = 8'd9;
        bif.rate_sel = 2'd3;
        pulse_start;
        wait_count("mid_cnt3", 8'd3, 100);
        clear_b = 1'b0;
        #1;
        check_val("mid_rst_state", 32'(bif.state), 32'(S_IDLE));
        check_val("mid_rst_cnt_en", 32'(bif.cnt_en), 0);
        check_val("mid_rst_clr_b", 32'(bif.cnt_clr_b), 1);
        check_val("mid_rst_busy", 32'(bif.busy), 0);
        np0 = npulse;
        cyc_n(3);
        clear_b = 1'b1;
        cyc_n(5);
        check_val("mid_rst_no_pulse", 32'(npulse - np0), 0);
        check_val("mid_rst_cnt_hold", 32'(bif.count), 3);
        check_val("mid_rst_idle", 32'(bif.state), 32'(S_IDLE));

`ifdef SEQ_AUTORELOAD_EN
        begin
            int nw0;
            int nd0;
            int maxc;
            bif.limit    = 8'd3;
            bif.rate_sel = 2'd3;
            nw0   = nwrap;
            nd0   = ndone;
            nclr0 = nclr;
            maxc  = 0;
            pulse_start;
            for (int i = 0; i < 60; i++) begin
                @(negedge clock);
                if (int'(bif.count) > maxc) maxc = int'(bif.count);
                if (bif.wrap) check_val("wrap_at_limit", 32'(bif.count), 3);
            end
            check_val("ar_max_count", 32'(maxc), 3);
            check_val("ar_wrap_seen", 32'(nwrap > nw0), 1);
            check_val("ar_wrap_per_clr", 32'(nwrap - nw0), 32'(nclr - nclr0 - 1));
            check_val("ar_no_done", 32'(ndone - nd0), 0);
            check_val("ar_busy", 32'(bif.busy), 1);
            pulse_stop;
            check_val("ar_hold", 32'(bif.state), 32'(S_HOLD));
        end
`else
        // limit=5 at the slowest rate.
        bif.limit    = 8'd5;
        bif.rate_sel = 2'd0;
        np0 = npulse;
        pulse_start;
        check_val("l5_clear_state", 32'(bif.state), 32'(S_CLEAR));
        check_val("l5_clr_low", 32'(bif.cnt_clr_b), 0);
        check_val("l5_busy", 32'(bif.busy), 1);
        cyc_n(1);
        check_val("l5_run_state", 32'(bif.state), 32'(S_RUN));
        check_val("l5_clr_high", 32'(bif.cnt_clr_b), 1);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (bif.cnt_en) begin
                first = i;
                break;
            end
        end
        check_val("l5_first_pulse_lat", 32'(first), 8);
        wait_state("l5_done_state", S_DONE, 100);
        check_val("l5_count", 32'(bif.count), 5);
        check_val("l5_pulses", 32'(npulse - np0), 5);
        check_val("l5_gap", 32'(gap), 8);
        check_val("l5_done", 32'(bif.done), 1);
        check_val("l5_busy_done", 32'(bif.busy), 0);
        pulse_stop;
        check_val("l5_stop_idle", 32'(bif.state), 32'(S_IDLE));

        // Fastest rate up to the top of the counter range.
        bif.limit    = 8'hFF;
        bif.rate_sel = 2'd3;
        np0 = npulse;
        pulse_start;
        wait_state("ff_done_state", S_DONE, 1000);
        check_val("ff_count", 32'(bif.count), 32'hFF);
        check_val("ff_pulses", 32'(npulse - np0), 255);
        check_val("ff_gap", 32'(gap), 2);
        check_val("ff_done", 32'(bif.done), 1);
        cyc_n(10);
        check_val("ff_no_wrap", 32'(bif.count), 32'hFF);
        pulse_stop;
        check_val("ff_stop_idle", 32'(bif.state), 32'(S_IDLE));

        // Pause, step (back-to-back steps), resume.
        bif.limit    = 8'd9;
        bif.rate_sel = 2'd0;
        pulse_start;
        wait_count("h_cnt4", 8'd4, 200);
        pulse_stop;
        check_val("h_hold_state", 32'(bif.state), 32'(S_HOLD));
        check_val("h_busy", 32'(bif.busy), 0);
        cyc_n(20);
        check_val("h_frozen", 32'(bif.count), 4);
        np0 = npulse;
        bif.step = 1'b1;
        cyc_n(3);
        bif.step = 1'b0;
        cyc_n(6);
        check_val("h_steps_count", 32'(bif.count), 7);
        check_val("h_steps_pulses", 32'(npulse - np0), 3);
        check_val("h_still_hold", 32'(bif.state), 32'(S_HOLD));
        nclr0 = nclr;
        pulse_start;
        check_val("h_resume_run", 32'(bif.state), 32'(S_RUN));
        wait_state("h_done_state", S_DONE, 200);
        check_val("h_final_count", 32'(bif.count), 9);
        check_val("h_no_clear", 32'(nclr - nclr0), 0);
        pulse_stop;
        check_val("h_done_stop_idle", 32'(bif.state), 32'(S_IDLE));
        check_val("h_done_low", 32'(bif.done), 0);

        // Coincident commands, step at limit, limit=0.
        bif.start = 1'b1;
        bif.stop  = 1'b1;
        cyc_n(1);
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        check_val("ss_idle", 32'(bif.state), 32'(S_IDLE));
        cyc_n(1);
        check_val("ss_idle2", 32'(bif.state), 32'(S_IDLE));
        np0 = npulse;
        pulse_step;
        check_val("step_at_lim_en", 32'(bif.cnt_en), 0);
        cyc_n(2);
        check_val("step_at_lim_pulses", 32'(npulse - np0), 0);
        check_val("step_at_lim_count", 32'(bif.count), 9);
        bif.limit = 8'd12;
        pulse_step;
        check_val("idle_step_lat", 32'(bif.cnt_en), 1);
        cyc_n(1);
        check_val("idle_step_count", 32'(bif.count), 10);
        bif.limit = 8'd0;
        np0 = npulse;
        pulse_start;
        wait_state("l0_done_state", S_DONE, 10);
        check_val("l0_count", 32'(bif.count), 0);
        check_val("l0_pulses", 32'(npulse - np0), 0);
        pulse_stop;
        check_val("l0_stop_idle", 32'(bif.state), 32'(S_IDLE));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
